// File: rtl/mod_exp_param.sv
// ----------------------------------------------------------------------------
// mod_exp_param
//
// Modular exponentiation engine: result = base^exponent mod modulus.
// One bit-serial interleaved modular multiplier is shared by every step:
//   RED : b <- b mod m          (computed as modmul(1, b))
//   MUL : r <- modmul(b, r)     (exponent bit is 1)
//   SQR : b <- modmul(b, b), e <- e >> 1
// Each modmul takes exactly WIDTH cycles whatever the operand values.
// The first cycle after an accepted start is a setup cycle. In that cycle
// degenerate moduli (0 and 1) finish without running the multiplier.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   start     in   1      job request, sampled only while idle
//   base      in   WIDTH  base operand (may be >= modulus)
//   exponent  in   WIDTH  exponent
//   modulus   in   WIDTH  modulus
//   busy      out  1      high whenever the engine is not idle
//   done      out  1      one-cycle pulse; result/err valid from this cycle
//   result    out  WIDTH  base^exponent mod modulus, held until next start
//   err       out  1      modulus was zero; held with result
// ----------------------------------------------------------------------------
module mod_exp_param #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] base,
   input  logic [WIDTH-1:0] exponent,
   input  logic [WIDTH-1:0] modulus,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             err
);

   // Accumulator needs two guard bits: before reduction it holds
   // 2*acc + x < 3*m < 2^(WIDTH+2).
   localparam int AW = WIDTH + 2;
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RED,
      S_MUL,
      S_SQR,
      S_DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] b;       // running base power (reduced after RED)
   logic [WIDTH-1:0] e;       // remaining exponent, shifted right by SQR
   logic [WIDTH-1:0] m;       // latched modulus
   logic [WIDTH-1:0] r;       // partial result
   logic [WIDTH-1:0] mm_x;    // multiplicand, always < m
   logic [WIDTH-1:0] mm_y;    // multiplier, scanned MSB first by shifting left
   logic [AW-1:0]    acc;     // interleaved partial product, always < m
   logic [CW-1:0]    cnt;     // multiplier step counter
   logic             mm_run;  // 0 during the setup cycle after start

   logic [AW-1:0]    m_ext;
   logic [AW-1:0]    acc_sh;
   logic [AW-1:0]    acc_s1;
   logic [AW-1:0]    acc_nxt;
   logic [WIDTH-1:0] prod;
   logic [WIDTH-1:0] e_sh;
   logic             last;

   // One interleaved multiply step: double, add the multiplicand when the
   // current multiplier bit is set, then at most two conditional subtracts
   // bring the value back below m.
   // NOTE: every signal assigned here gets a value on every path, so the
   // block stays purely combinational and no latch is inferred.
   always_comb begin
      m_ext   = {2'b00, m};
      acc_sh  = {acc[AW-2:0], 1'b0} + (mm_y[WIDTH-1] ? {2'b00, mm_x} : '0);
      acc_s1  = (acc_sh >= m_ext) ? acc_sh - m_ext : acc_sh;
      acc_nxt = (acc_s1 >= m_ext) ? acc_s1 - m_ext : acc_s1;
      prod    = acc_nxt[WIDTH-1:0];
      e_sh    = e >> 1;
      last    = mm_run && (cnt == CW'(WIDTH - 1));
   end

   // NOTE: every register, including the operand latches, is cleared by the
   // asynchronous reset so an aborted job leaves no stale state behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         b      <= '0;
         e      <= '0;
         m      <= '0;
         r      <= '0;
         mm_x   <= '0;
         mm_y   <= '0;
         acc    <= '0;
         cnt    <= '0;
         mm_run <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         err    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout; a later assignment to
         // the same register in this block (the phase-change reload below)
         // deliberately overrides this default step.
         if (mm_run) begin
            acc  <= acc_nxt;
            mm_y <= mm_y << 1;
            cnt  <= cnt + 1'b1;
         end

         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  b      <= base;
                  e      <= exponent;
                  m      <= modulus;
                  acc    <= '0;
                  cnt    <= '0;
                  mm_run <= 1'b0;
                  result <= '0;
                  err    <= 1'b0;
                  busy   <= 1'b1;
                  state  <= S_RED;
               end
            end

            S_RED: begin
               if (!mm_run) begin
                  // Setup cycle: settle degenerate moduli or arm b mod m.
                  if (m == '0) begin
                     result <= '0;
                     err    <= 1'b1;
                     done   <= 1'b1;
                     state  <= S_DONE;
                  end else if (m == WIDTH'(1)) begin
                     result <= '0;
                     done   <= 1'b1;
                     state  <= S_DONE;
                  end else begin
                     r      <= WIDTH'(1);
                     mm_x   <= WIDTH'(1);
                     mm_y   <= b;
                     acc    <= '0;
                     cnt    <= '0;
                     mm_run <= 1'b1;
                  end
               end else if (last) begin
                  b   <= prod;
                  acc <= '0;
                  cnt <= '0;
                  if (e == '0) begin
                     result <= WIDTH'(1);
                     mm_run <= 1'b0;
                     done   <= 1'b1;
                     state  <= S_DONE;
                  end else if (e[0]) begin
                     mm_x  <= prod;
                     mm_y  <= r;
                     state <= S_MUL;
                  end else begin
                     mm_x  <= prod;
                     mm_y  <= prod;
                     state <= S_SQR;
                  end
               end
            end

            S_MUL: begin
               if (last) begin
                  r   <= prod;
                  acc <= '0;
                  cnt <= '0;
                  if (e_sh == '0) begin
                     result <= prod;
                     mm_run <= 1'b0;
                     done   <= 1'b1;
                     state  <= S_DONE;
                  end else begin
                     mm_x  <= b;
                     mm_y  <= b;
                     state <= S_SQR;
                  end
               end
            end

            S_SQR: begin
               // Only entered while e >> 1 != 0, so another MUL always follows.
               if (last) begin
                  b   <= prod;
                  e   <= e_sh;
                  acc <= '0;
                  cnt <= '0;
                  mm_x <= prod;
                  if (e_sh[0]) begin
                     mm_y  <= r;
                     state <= S_MUL;
                  end else begin
                     mm_y  <= prod;
                     state <= S_SQR;
                  end
               end
            end

            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mod_exp_param.sv
// ----------------------------------------------------------------------------
// tb_mod_exp_param
//
// Directed bench for mod_exp_param. A 32-bit instance runs the hand-computed
// vectors (normal job, base reduction, exponent zero, degenerate moduli,
// ignored start, start held across DONE, mid-job reset). An 8-bit instance
// runs a parameter sweep against a small reference model, checking the
// result and the exact cycle latency.
// ----------------------------------------------------------------------------
module tb_mod_exp_param;

   localparam int LIMIT = 2000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic        start32 = 1'b0;
   logic [31:0] base32 = '0, exp32 = '0, mod32 = '0;
   logic        busy32, done32, err32;
   logic [31:0] res32;

   logic        start8 = 1'b0;
   logic [7:0]  base8 = '0, exp8 = '0, mod8 = '0;
   logic        busy8, done8, err8;
   logic [7:0]  res8;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mod_exp_param #(.WIDTH(32)) u_dut32 (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start32),
      .base     (base32),
      .exponent (exp32),
      .modulus  (mod32),
      .busy     (busy32),
      .done     (done32),
      .result   (res32),
      .err      (err32)
   );

   mod_exp_param #(.WIDTH(8)) u_dut8 (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start8),
      .base     (base8),
      .exponent (exp8),
      .modulus  (mod8),
      .busy     (busy8),
      .done     (done8),
      .result   (res8),
      .err      (err8)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: square-and-multiply with 64-bit intermediates.
   function automatic int ref_modexp8(input int b, input int e, input int m);
      longint r  = 1;
      longint bb = longint'(b) % m;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) r = (r * bb) % m;
         bb = (bb * bb) % m;
      end
      return int'(r % m);
   endfunction

   function automatic int lat8(input int e);
      int l = 0;
      int p = 0;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) begin
            l = i + 1;
            p++;
         end
      end
      return (e == 0) ? 9 : 1 + 8 * (1 + p + l - 1);
   endfunction

   // All tasks start and end 1 time unit after a rising edge.
   task automatic launch32(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m);
      base32 = b; exp32 = e; mod32 = m; start32 = 1'b1;
      @(posedge clk); #1;   // edge 0
      start32 = 1'b0;
   endtask

   task automatic wait32(input int n0, output int n, output bit busy_ok);
      n = n0;
      busy_ok = 1'b1;
      while (n <= LIMIT) begin
         @(posedge clk); #1;
         n++;
         if (!busy32) busy_ok = 1'b0;
         if (done32) break;
      end
   endtask

   task automatic run32(input string tag, input logic [31:0] b, input logic [31:0] e,
                        input logic [31:0] m, input logic [31:0] xr, input logic xe, input int xl);
      int n;
      bit ok;
      launch32(b, e, m);
      chk({tag, "_busy_rise"}, busy32, 1'b1);
      wait32(0, n, ok);
      chk({tag, "_latency"}, n, xl);
      chk({tag, "_result"}, res32, xr);
      chk({tag, "_err"}, err32, xe);
      chk({tag, "_busy_held"}, ok, 1'b1);
      @(posedge clk); #1;
      chk({tag, "_done_fall"}, done32, 1'b0);
      chk({tag, "_busy_fall"}, busy32, 1'b0);
      chk({tag, "_result_hold"}, res32, xr);
   endtask

   task automatic run8(input int b, input int e, input int m);
      int n = 0;
      base8 = 8'(b); exp8 = 8'(e); mod8 = 8'(m); start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      while (n <= LIMIT) begin
         @(posedge clk); #1;
         n++;
         if (done8) break;
      end
      chk($sformatf("w8_lat_%0d_%0d_%0d", b, e, m), n, lat8(e));
      chk($sformatf("w8_res_%0d_%0d_%0d", b, e, m), res8, ref_modexp8(b, e, m));
      @(posedge clk); #1;
   endtask

   initial begin
      int n;
      bit ok;

      // Reset state
      #12;
      chk("rst_busy", busy32, 1'b0);
      chk("rst_done", done32, 1'b0);
      chk("rst_result", res32, 32'd0);
      chk("rst_err", err32, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Main job: 4^13 mod 497 = 445, L=4, P=3 -> 1 + 32*7 = 225
      run32("pow4_13", 32'd4, 32'd13, 32'd497, 32'd445, 1'b0, 225);

      // Base above modulus: (0xFFFFFFFF mod 0xFFFFFFFB)=4, 4^2=16; L=2,P=1 -> 97
      run32("reduce", 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFB, 32'd16, 1'b0, 97);

      // Exponent zero, then the two degenerate moduli
      run32("exp0", 32'd7, 32'd0, 32'd13, 32'd1, 1'b0, 33);
      run32("mod0", 32'd7, 32'd0, 32'd0, 32'd0, 1'b1, 1);
      run32("mod1", 32'd5, 32'd3, 32'd1, 32'd0, 1'b0, 1);

      // Start pulse mid-job with other operands is ignored
      launch32(32'd4, 32'd13, 32'd497);
      repeat (39) begin
         @(posedge clk); #1;
      end
      base32 = 32'd9; exp32 = 32'd3; mod32 = 32'd100; start32 = 1'b1;
      @(posedge clk); #1;   // edge 40, engine busy
      start32 = 1'b0;
      wait32(40, n, ok);
      chk("ignore_latency", n, 225);
      chk("ignore_result", res32, 32'd445);
      chk("ignore_busy_held", ok, 1'b1);
      @(posedge clk); #1;
      chk("ignore_idle", busy32, 1'b0);

      // start held high across DONE: second job accepted 2 edges after done
      base32 = 32'd7; exp32 = 32'd0; mod32 = 32'd13; start32 = 1'b1;
      @(posedge clk); #1;
      wait32(0, n, ok);
      chk("held_first_latency", n, 33);
      @(posedge clk); #1;   // DONE -> IDLE, start in DONE ignored
      chk("held_idle_gap", busy32, 1'b0);
      @(posedge clk); #1;   // IDLE samples start
      chk("held_accept", busy32, 1'b1);
      start32 = 1'b0;
      wait32(0, n, ok);
      chk("held_second_latency", n, 33);
      chk("held_second_result", res32, 32'd1);
      @(posedge clk); #1;

      // Reset just before edge 100 of the 4^13 job aborts it
      launch32(32'd4, 32'd13, 32'd497);
      repeat (99) begin
         @(posedge clk); #1;
      end
      chk("pre_rst_busy", busy32, 1'b1);
      #7 rst_n = 1'b0;
      #1;
      chk("abort_busy", busy32, 1'b0);
      chk("abort_result", res32, 32'd0);
      chk("abort_err", err32, 1'b0);
      ok = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         if (done32 || busy32) ok = 1'b0;
      end
      chk("abort_quiet", ok, 1'b1);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run32("after_rst", 32'd4, 32'd13, 32'd497, 32'd445, 1'b0, 225);

      // WIDTH=8 sweep: corner vectors then random ones
      run8(254, 255, 255);
      run8(3, 255, 255);
      run8(200, 0, 7);
      run8(255, 255, 2);
      run8(17, 128, 251);
      run8(2, 1, 3);
      for (int k = 0; k < 16; k++) begin
         run8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(2, 255)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
